// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the cache-to-memory port arbiter.
package mem_arb_pkg;
   localparam int LINE_BITS     = 256;
   localparam int BEAT_BITS     = 64;
   localparam int BEATS         = LINE_BITS / BEAT_BITS;
   localparam int ADDR_BITS     = 32;
   localparam int BEAT_IDX_BITS = $clog2(BEATS);

   localparam logic [ADDR_BITS-1:0] OFFSET_MASK = ADDR_BITS'(LINE_BITS / 8 - 1);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_DATA, DONE} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;
   typedef logic [BEAT_IDX_BITS-1:0] beat_t;

   function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] a);
      return a & ~OFFSET_MASK;
   endfunction

   function automatic int beat_lsb(input beat_t b);
      return BEAT_BITS * int'(b);
   endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache request/response and burst-memory signals of the shared memory port.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic                 i_req;
   logic [ADDR_BITS-1:0] i_addr;
   logic                 i_resp;
   logic [LINE_BITS-1:0] i_rdata;

   logic                 d_req;
   logic                 d_we;
   logic [ADDR_BITS-1:0] d_addr;
   logic [LINE_BITS-1:0] d_wdata;
   logic                 d_resp;
   logic [LINE_BITS-1:0] d_rdata;

   logic [ADDR_BITS-1:0] bmem_addr;
   logic                 bmem_read;
   logic                 bmem_write;
   logic [BEAT_BITS-1:0] bmem_wdata;
   logic                 bmem_ready;
   logic [BEAT_BITS-1:0] bmem_rdata;
   logic                 bmem_rvalid;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      input  bmem_ready, bmem_rdata, bmem_rvalid,
      output i_resp, i_rdata, d_resp, d_rdata,
      output bmem_addr, bmem_read, bmem_write, bmem_wdata
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
      output bmem_ready, bmem_rdata, bmem_rvalid,
      input  i_resp, i_rdata, d_resp, d_rdata,
      input  bmem_addr, bmem_read, bmem_write, bmem_wdata
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: combinational pick, last winner remembered on update.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_req_i,
   input  logic   d_req_i,
   input  logic   upd_i,
   input  owner_t upd_owner_i,
   output logic   gnt_valid_o,
   output owner_t gnt_o
);
   owner_t last_q, last_d;

   // NOTE: non-blocking assignment in clocked logic so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) last_q <= OWN_D;
      else      last_q <= last_d;
   end

   // NOTE: every output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      last_d      = last_q;
      gnt_valid_o = i_req_i | d_req_i;
      gnt_o       = OWN_I;
      if (upd_i) last_d = upd_owner_i;
      if (i_req_i && d_req_i) gnt_o = (last_q == OWN_D) ? OWN_I : OWN_D;
      else if (d_req_i)       gnt_o = OWN_D;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 4-beat burst memory port between the icache and dcache, one line at a time.
module mem_port_arbiter
   import mem_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.master bus
);
   state_t               state_q, state_d;
   owner_t               owner_q, owner_d;
   logic                 we_q, we_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [LINE_BITS-1:0] wline_q, wline_d;
   logic [LINE_BITS-1:0] line_buf_q, line_buf_d;
   beat_t                beat_q, beat_d;
   logic                 gnt_valid;
   owner_t               gnt;

   rr_arb2 u_rr_arb2 (
      .clk        (clk),
      .rst        (rst),
      .i_req_i    (bus.i_req),
      .d_req_i    (bus.d_req),
      .upd_i      (state_q == DONE),
      .upd_owner_i(owner_q),
      .gnt_valid_o(gnt_valid),
      .gnt_o      (gnt)
   );

   // NOTE: the line buffers are ordinary flops, so clearing them on reset is cheap; a RAM could not be.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_I;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wline_q    <= '0;
         line_buf_q <= '0;
         beat_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wline_q    <= wline_d;
         line_buf_q <= line_buf_d;
         beat_q     <= beat_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wline_d    = wline_q;
      line_buf_d = line_buf_q;
      beat_d     = beat_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt;
               we_d    = (gnt == OWN_D) && bus.d_we;
               addr_d  = line_align((gnt == OWN_D) ? bus.d_addr : bus.i_addr);
               if (we_d) wline_d = bus.d_wdata;
               beat_d  = '0;
               state_d = we_d ? WR_DATA : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (bus.bmem_ready) begin
               beat_d  = '0;
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            if (bus.bmem_rvalid) begin
               line_buf_d[beat_lsb(beat_q) +: BEAT_BITS] = bus.bmem_rdata;
               beat_d = beat_q + 1'b1;
               if (beat_q == beat_t'(BEATS - 1)) state_d = DONE;
            end
         end
         WR_DATA: begin
            if (bus.bmem_ready) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == beat_t'(BEATS - 1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode registered state only; bmem inputs never reach the cache side combinationally.
   always_comb begin
      bus.bmem_read  = (state_q == RD_ADDR);
      bus.bmem_write = (state_q == WR_DATA);
      bus.bmem_addr  = (state_q inside {RD_ADDR, RD_DATA, WR_DATA}) ? addr_q : '0;
      bus.bmem_wdata = (state_q == WR_DATA) ? wline_q[beat_lsb(beat_q) +: BEAT_BITS] : '0;
      bus.i_resp     = (state_q == DONE) && (owner_q == OWN_I);
      bus.d_resp     = (state_q == DONE) && (owner_q == OWN_D);
      bus.i_rdata    = ((state_q == DONE) && (owner_q == OWN_I)) ? line_buf_q : '0;
      bus.d_rdata    = ((state_q == DONE) && (owner_q == OWN_D)) ? line_buf_q : '0;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: burst memory model, request table and response scoreboard.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      owner_t               owner;
      logic                 we;
      logic [ADDR_BITS-1:0] addr;
      logic [LINE_BITS-1:0] line;
   } exp_t;

   typedef struct {
      string                name;
      logic                 ireq;
      logic                 dreq;
      logic                 dwe;
      logic [ADDR_BITS-1:0] iaddr;
      logic [ADDR_BITS-1:0] daddr;
      logic [LINE_BITS-1:0] wline;
      owner_t               first;
   } vec_t;

   exp_t                 sb[$];
   logic [BEAT_BITS-1:0] wr_log[$];
   int                   resp_log[$];
   vec_t                 vecs[6];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic                 toggle_mode = 1'b0;
   logic                 wr_phase    = 1'b1;
   logic                 spurious    = 1'b0;
   int                   rd_left     = 0;
   int                   rd_k        = 0;
   logic [ADDR_BITS-1:0] rd_addr     = '0;
   logic [ADDR_BITS-1:0] cur_addr    = '0;
   int                   last_resp_cyc   = -100;
   int                   last_acc_cyc    = 0;
   int                   first_start_cyc = -1;
   int                   issue_cyc       = 0;
   int                   wr_cycles       = 0;
   logic                 prev_active     = 1'b0;
   logic                 prev_wr_stall   = 1'b0;
   logic [BEAT_BITS-1:0] prev_wdata      = '0;

   function automatic logic [BEAT_BITS-1:0] mem_beat(input logic [ADDR_BITS-1:0] a, input int k);
      return {a, 24'h0, 8'hA0 + 8'(k)};
   endfunction

   function automatic logic [LINE_BITS-1:0] mem_line(input logic [ADDR_BITS-1:0] a);
      return {mem_beat(a, 3), mem_beat(a, 2), mem_beat(a, 1), mem_beat(a, 0)};
   endfunction

   function automatic logic [ADDR_BITS-1:0] align(input logic [ADDR_BITS-1:0] a);
      return a & 32'hFFFF_FFE0;
   endfunction

   task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                        input logic [LINE_BITS-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: cycle budget expired at cycle %0d", name, cyc);
   endtask

   // One clock cycle: memory drives this cycle's inputs, then DUT outputs are scored.
   task automatic tick();
      exp_t e;
      logic active;
      @(negedge clk);
      cyc++;
      if (toggle_mode && bus.bmem_write) begin
         bus.bmem_ready = wr_phase;
         wr_phase       = ~wr_phase;
      end else begin
         bus.bmem_ready = 1'b1;
         wr_phase       = 1'b1;
      end
      if (!rst) rd_left = 0;
      if (rd_left > 0) begin
         bus.bmem_rvalid = 1'b1;
         bus.bmem_rdata  = mem_beat(rd_addr, rd_k);
         rd_k++;
         rd_left--;
      end else if (spurious) begin
         bus.bmem_rvalid = 1'b1;
         bus.bmem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
         bus.bmem_rvalid = 1'b0;
         bus.bmem_rdata  = '0;
      end
      if (bus.bmem_read && bus.bmem_ready) begin
         rd_left = BEATS;
         rd_k    = 0;
         rd_addr = bus.bmem_addr;
      end

      active = bus.bmem_read | bus.bmem_write;
      if (active && !prev_active) begin
         if (first_start_cyc < 0) first_start_cyc = cyc;
         check("idle_gap_after_resp", LINE_BITS'(cyc - last_resp_cyc >= 2), LINE_BITS'(1));
         cur_addr = bus.bmem_addr;
      end
      prev_active = active;

      if (bus.bmem_write) begin
         wr_cycles++;
         if (prev_wr_stall) check("wdata_held_while_stalled", LINE_BITS'(bus.bmem_wdata), LINE_BITS'(prev_wdata));
         if (bus.bmem_ready) begin
            wr_log.push_back(bus.bmem_wdata);
            last_acc_cyc = cyc;
         end
         prev_wr_stall = !bus.bmem_ready;
         prev_wdata    = bus.bmem_wdata;
      end else begin
         prev_wr_stall = 1'b0;
      end

      if (bus.i_resp || bus.d_resp) begin
         last_resp_cyc = cyc;
         resp_log.push_back(cyc);
         check("resp_exclusive", LINE_BITS'(bus.i_resp & bus.d_resp), LINE_BITS'(0));
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b at cycle %0d, none outstanding",
                     bus.i_resp, bus.d_resp, cyc);
         end else begin
            e = sb.pop_front();
            check("resp_owner", LINE_BITS'(bus.d_resp ? OWN_D : OWN_I), LINE_BITS'(e.owner));
            check("bmem_addr", LINE_BITS'(cur_addr), LINE_BITS'(e.addr));
            if (e.we) begin
               check("wr_beat_count", LINE_BITS'(wr_log.size()), LINE_BITS'(BEATS));
               if (wr_log.size() == BEATS)
                  check("wr_line", {wr_log[3], wr_log[2], wr_log[1], wr_log[0]}, e.line);
               check("wr_resp_latency", LINE_BITS'(cyc - last_acc_cyc), LINE_BITS'(1));
            end else begin
               check("rd_line", bus.i_resp ? bus.i_rdata : bus.d_rdata, e.line);
            end
         end
         wr_log.delete();
         if (bus.i_resp) bus.i_req = 1'b0;
         if (bus.d_resp) bus.d_req = 1'b0;
      end
   endtask

   task automatic issue(input vec_t v);
      exp_t ei, ed;
      ei = '{owner: OWN_I, we: 1'b0, addr: align(v.iaddr), line: mem_line(align(v.iaddr))};
      ed = '{owner: OWN_D, we: v.dwe, addr: align(v.daddr),
             line: v.dwe ? v.wline : mem_line(align(v.daddr))};
      if (v.ireq) begin
         bus.i_req  = 1'b1;
         bus.i_addr = v.iaddr;
      end
      if (v.dreq) begin
         bus.d_req   = 1'b1;
         bus.d_we    = v.dwe;
         bus.d_addr  = v.daddr;
         bus.d_wdata = v.wline;
      end
      if (v.first == OWN_I) begin
         if (v.ireq) sb.push_back(ei);
         if (v.dreq) sb.push_back(ed);
      end else begin
         if (v.dreq) sb.push_back(ed);
         if (v.ireq) sb.push_back(ei);
      end
      issue_cyc       = cyc;
      first_start_cyc = -1;
   endtask

   task automatic wait_all(input string name, input int budget);
      int n = 0;
      while ((bus.i_req || bus.d_req) && n < budget) begin
         tick();
         n++;
      end
      if (bus.i_req || bus.d_req) begin
         expire({name, "_timeout"});
         bus.i_req = 1'b0;
         bus.d_req = 1'b0;
         sb.delete();
      end
      tick();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_i_resp"},     LINE_BITS'(bus.i_resp),     '0);
      check({tag, "_d_resp"},     LINE_BITS'(bus.d_resp),     '0);
      check({tag, "_bmem_read"},  LINE_BITS'(bus.bmem_read),  '0);
      check({tag, "_bmem_write"}, LINE_BITS'(bus.bmem_write), '0);
      check({tag, "_bmem_addr"},  LINE_BITS'(bus.bmem_addr),  '0);
      check({tag, "_bmem_wdata"}, LINE_BITS'(bus.bmem_wdata), '0);
      check({tag, "_i_rdata"},    bus.i_rdata,                '0);
      check({tag, "_d_rdata"},    bus.d_rdata,                '0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      tick();
      tick();
      check_quiet(tag);
      rst = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n;
      rst             = 1'b0;
      bus.i_req       = 1'b0;
      bus.i_addr      = '0;
      bus.d_req       = 1'b0;
      bus.d_we        = 1'b0;
      bus.d_addr      = '0;
      bus.d_wdata     = '0;
      bus.bmem_ready  = 1'b0;
      bus.bmem_rdata  = '0;
      bus.bmem_rvalid = 1'b0;

      vecs[0] = '{name: "tie_after_reset", ireq: 1'b1, dreq: 1'b1, dwe: 1'b0, iaddr: 32'h0000_1234,
                  daddr: 32'h0000_4008, wline: '0, first: OWN_I};
      vecs[1] = '{name: "tie_again", ireq: 1'b1, dreq: 1'b1, dwe: 1'b1, iaddr: 32'h0000_3010,
                  daddr: 32'h0000_5000, wline: {64'h1111_2222, 64'h3333_4444, 64'h5555_6666, 64'h7777_8888},
                  first: OWN_I};
      vecs[2] = '{name: "i_only", ireq: 1'b1, dreq: 1'b0, dwe: 1'b0, iaddr: 32'h7FFF_FFE7,
                  daddr: '0, wline: '0, first: OWN_I};
      vecs[3] = '{name: "tie_after_i", ireq: 1'b1, dreq: 1'b1, dwe: 1'b0, iaddr: 32'h0000_0600,
                  daddr: 32'h0000_071F, wline: '0, first: OWN_D};
      vecs[4] = '{name: "d_only_write", ireq: 1'b0, dreq: 1'b1, dwe: 1'b1, iaddr: '0,
                  daddr: 32'hFFFF_FFFF, wline: {4{64'hCAFE_F00D_1234_5678}} ^ {64'h3, 64'h2, 64'h1, 64'h0},
                  first: OWN_D};
      vecs[5] = '{name: "tie_after_d", ireq: 1'b1, dreq: 1'b1, dwe: 1'b0, iaddr: 32'h0000_0000,
                  daddr: 32'h0000_0020, wline: '0, first: OWN_I};

      // Lone icache read straight out of reset: request to response in six cycles.
      do_reset("reset");
      v = '{name: "i_read", ireq: 1'b1, dreq: 1'b0, dwe: 1'b0, iaddr: 32'h0000_1234,
            daddr: '0, wline: '0, first: OWN_I};
      issue(v);
      wait_all("i_read", 40);
      check("i_read_latency", LINE_BITS'(last_resp_cyc - issue_cyc), LINE_BITS'(6));
      check("i_read_first_bmem", LINE_BITS'(first_start_cyc - issue_cyc), LINE_BITS'(1));

      // Arbitration table, starting from a fresh last_grant.
      do_reset("reset2");
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i]);
         wait_all(vecs[i].name, 60);
         check({vecs[i].name, "_first_bmem"}, LINE_BITS'(first_start_cyc - issue_cyc), LINE_BITS'(1));
      end

      // dcache write with ready toggling 1,0,1,0...
      toggle_mode = 1'b1;
      wr_cycles   = 0;
      v = '{name: "toggle_write", ireq: 1'b0, dreq: 1'b1, dwe: 1'b1, iaddr: '0, daddr: 32'h0000_0080,
            wline: {64'd4, 64'd3, 64'd2, 64'd1}, first: OWN_D};
      issue(v);
      wait_all("toggle_write", 40);
      check("toggle_write_cycles", LINE_BITS'(wr_cycles), LINE_BITS'(7));
      toggle_mode = 1'b0;

      // dcache request arriving mid icache burst is granted right after the icache response.
      resp_log.delete();
      v = '{name: "late_d_i", ireq: 1'b1, dreq: 1'b0, dwe: 1'b0, iaddr: 32'h0000_2000,
            daddr: '0, wline: '0, first: OWN_I};
      issue(v);
      repeat (3) tick();
      v = '{name: "late_d", ireq: 1'b0, dreq: 1'b1, dwe: 1'b0, iaddr: '0,
            daddr: 32'h0000_2040, wline: '0, first: OWN_D};
      issue(v);
      wait_all("late_d", 60);
      check("late_d_resp_count", LINE_BITS'(resp_log.size()), LINE_BITS'(2));
      if (resp_log.size() == 2)
         check("late_d_spacing", LINE_BITS'(resp_log[1] - resp_log[0]), LINE_BITS'(7));

      // Reset lands after two read beats are captured; the transaction vanishes.
      v = '{name: "abort_read", ireq: 1'b1, dreq: 1'b0, dwe: 1'b0, iaddr: 32'h0000_9000,
            daddr: '0, wline: '0, first: OWN_I};
      issue(v);
      n = 0;
      while (rd_k < 3 && n < 40) begin
         tick();
         n++;
      end
      if (rd_k < 3) expire("abort_wait_beats");
      rst       = 1'b0;
      bus.i_req = 1'b0;
      sb.delete();
      tick();
      check_quiet("abort");
      rst = 1'b1;
      repeat (4) tick();
      v = '{name: "after_abort", ireq: 1'b1, dreq: 1'b0, dwe: 1'b0, iaddr: 32'h0000_9004,
            daddr: '0, wline: '0, first: OWN_I};
      issue(v);
      wait_all("after_abort", 40);

      // Stray rvalid while idle and while writing.
      spurious = 1'b1;
      repeat (5) tick();
      v = '{name: "spur_write", ireq: 1'b0, dreq: 1'b1, dwe: 1'b1, iaddr: '0, daddr: 32'h0000_0100,
            wline: {64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD}, first: OWN_D};
      issue(v);
      wait_all("spur_write", 40);
      repeat (3) tick();
      spurious = 1'b0;
      v = '{name: "spur_read", ireq: 1'b1, dreq: 1'b0, dwe: 1'b0, iaddr: 32'h0000_0140,
            daddr: '0, wline: '0, first: OWN_I};
      issue(v);
      wait_all("spur_read", 40);
      repeat (3) tick();
      check("scoreboard_drained", LINE_BITS'(sb.size()), LINE_BITS'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
